l1_refill_arbiter: RTL and testbench
====================================

Name: l1_refill_arbiter

Overview:
- Shares the single L2 instruction port among the per-thread L1 line buffers, one buffer per hardware thread.
- Collects each thread's refill, branch-prefetch and sequential-prefetch requests. It picks one request by class priority, with round-robin between threads inside a class.
- Issues the request to L2 with a valid/ready handshake. It then broadcasts the returned line to all L1 buffers, tagged with the owning TID and block address.
- Allows one L2 transaction in flight.

Parameters:
- NUM_THREADS, 4, number of hardware threads / L1 buffers; must be a power of 2; TID width = TID_bits = $clog2(NUM_THREADS).
- LINE_BYTES, 16, line size in bytes; request addresses are aligned by clearing the low $clog2(LINE_BYTES) bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- req_refill  in  NUM_THREADS  per-thread demand miss (level, held until the line arrives).
- br_req  in  NUM_THREADS  per-thread branch-target prefetch request (level).
- req_spec  in  NUM_THREADS  per-thread sequential prefetch request (level).
- refill_addr  in  NUM_THREADS x 32  per-thread fetch PC for a refill.
- br_addr  in  NUM_THREADS x 32  per-thread branch target.
- spec_addr  in  NUM_THREADS x 32  per-thread next-line address (current block + LINE_BYTES).
- l2_req_valid  out  1  request to L2.
- l2_req_ready  in  1  L2 accepts the request.
- l2_req_addr  out  32  line-aligned request address.
- l2_req_tid  out  TID_bits  requesting thread.
- l2_rsp_valid  in  1  L2 returns a line (one cycle).
- l2_rsp_line  in  128  returned line.
- rsp_valid  out  1  broadcast strobe to L1 buffers.
- tid_from_l2  out  TID_bits  owner of the broadcast line.
- PC_L2_i  out  32  aligned block address of the broadcast line.
- l2_cache_block_rsp  out  128  broadcast line data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset==0 at a clk edge):
  - FSM goes to IDLE; rr_ptr=0; all spec_done bits = 0.
  - Outputs go to 0: l2_req_valid, l2_req_addr, l2_req_tid, rsp_valid, tid_from_l2, PC_L2_i, l2_cache_block_rsp.
  - Reset wins over any other event in the same cycle.
  - A transaction in flight is abandoned. A late l2_rsp_valid is ignored because the FSM is not in WAIT.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Evaluate eligible requests:
    - refill[t] = req_refill[t];
    - branch[t] = br_req[t];
    - spec[t] = req_spec[t] && !(spec_done[t] && spec_last[t]==align(spec_addr[t])).
  - Class priority: refill > branch > spec.
  - Within the highest non-empty class, grant the first set thread scanning rr_ptr, rr_ptr+1, ... modulo NUM_THREADS.
  - On a grant, register l2_req_addr=align(selected addr), l2_req_tid=t and l2_req_valid=1; set rr_ptr=t+1 (wraps); go to ISSUE.
  - For a spec grant, also set spec_last[t]=align(addr) and spec_done[t]=1.
  - No eligible request: stay in IDLE.
- ISSUE:
  - Hold l2_req_valid, addr and tid stable until l2_req_ready=1.
  - On that edge, clear l2_req_valid and go to WAIT.
  - l2_rsp_valid is ignored in this state.
- WAIT:
  - On l2_rsp_valid, register l2_cache_block_rsp=l2_rsp_line, tid_from_l2=l2_req_tid, PC_L2_i=l2_req_addr, rsp_valid=1; go to RESP.
  - No timeout.
- RESP:
  - rsp_valid stays high for exactly this one cycle; next state is IDLE.
  - No arbitration happens in RESP, so each L1 buffer has updated its block address before its request levels are sampled again. This prevents a duplicate refill.
- Latency:
  - A request seen in IDLE at cycle n gives l2_req_valid at n+1.
  - l2_rsp_valid at cycle k gives rsp_valid at k+1 and IDLE at k+2.
  - Minimum turnaround is 4 cycles with ready=1 and a 1-cycle L2.
- Requests dropping while the FSM is in ISSUE or WAIT do not cancel the transaction; the line is still broadcast.
- Data and address outputs keep their last value outside RESP; consumers qualify them with rsp_valid.
- Wrap-around:
  - rr_ptr wraps from NUM_THREADS-1 to 0.
  - align(0xFFFFFFFC) = 0xFFFFFFF0.
  - spec_addr wraps naturally in 32-bit arithmetic; that is the producer's responsibility.

Decomposition:
- Add to package fgmt:
  - arb_state_e {IDLE, ISSUE, WAIT, RESP};
  - req_class_e {CLS_REFILL, CLS_BRANCH, CLS_SPEC};
  - LINE_BYTES constant.
- Reuse the existing fgmt word, line and TID_bits.
- Sub-module rr_picker: NUM_THREADS-wide request vector plus rr_ptr in, found flag plus granted index out. Purely combinational.
- Instantiate rr_picker three times, once per class.

Test Plan:
- Single refill: T2 req_refill=1, refill_addr=0x0000_1234, l2_req_ready=1, L2 responds 2 cycles after the handshake → l2_req_addr=0x0000_1230 with tid 2. rsp_valid is high for one cycle with tid_from_l2=2 and PC_L2_i=0x0000_1230. Exactly one L2 request is issued.
- Priority: same cycle T0 req_spec, T1 br_req, T3 req_refill → grant order T3 (refill), then T1 (branch), then T0 (spec).
- Round-robin: all four threads hold req_refill continuously, rr_ptr=0 → grant order 0,1,2,3,0.
- Spec dedup: T1 req_spec held with spec_addr=0x100 → one L2 request to 0x100. No re-issue while spec_addr stays 0x100. Changing it to 0x110 issues a new request.
- Back-pressure: l2_req_ready low for 5 cycles → l2_req_valid, addr and tid are stable for all 5 cycles. A spurious l2_rsp_valid during ISSUE produces no rsp_valid.
- Reset mid-WAIT: reset=0 for one cycle while in WAIT, then L2 responds → no rsp_valid, busy=0, and arbitration restarts with rr_ptr=0.

Source files
------------

// File: rtl/l1_refill_arbiter_pkg.sv
// Shared fetch-group types and constants for the L1 refill arbiter.
// Holds the word/line types, the arbiter FSM states and the request classes.
package fgmt;

    localparam int WORD_W     = 32;
    localparam int LINE_W     = 128;
    localparam int TID_bits   = 2;
    localparam int LINE_BYTES = 16;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        CLS_REFILL = 2'd0,
        CLS_BRANCH = 2'd1,
        CLS_SPEC   = 2'd2
    } req_class_e;

endpackage

// File: rtl/l1_refill_arbiter_rr_picker.sv
// Round-robin picker: first set request scanning from ptr upwards, modulo N.
// Purely combinational; N must be a power of two so index arithmetic wraps.
module rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0] cand_s;
    logic         hit_s;

    // Scan candidates in rotated order; the first hit is latched and later hits are masked.
    always_comb begin
        found  = 1'b0;
        idx    = {W{1'b0}};
        cand_s = {W{1'b0}};
        hit_s  = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand_s = ptr + W'(k);
            hit_s  = !found && req[cand_s];
            found  = found | hit_s;
            idx    = hit_s ? cand_s : idx;
        end
    end

endmodule

// File: rtl/l1_refill_arbiter.sv
// Arbitrates per-thread refill / branch / sequential-prefetch requests onto the
// single L2 instruction port and broadcasts each returned line to all L1 buffers.
module l1_refill_arbiter #(
    parameter int NUM_THREADS = 4,
    parameter int LINE_BYTES  = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_THREADS-1:0]               req_refill,
    input  logic [NUM_THREADS-1:0]               br_req,
    input  logic [NUM_THREADS-1:0]               req_spec,
    input  logic [NUM_THREADS-1:0][31:0]         refill_addr,
    input  logic [NUM_THREADS-1:0][31:0]         br_addr,
    input  logic [NUM_THREADS-1:0][31:0]         spec_addr,
    output logic                                 l2_req_valid,
    input  logic                                 l2_req_ready,
    output logic [31:0]                          l2_req_addr,
    output logic [$clog2(NUM_THREADS)-1:0]       l2_req_tid,
    input  logic                                 l2_rsp_valid,
    input  logic [127:0]                         l2_rsp_line,
    output logic                                 rsp_valid,
    output logic [$clog2(NUM_THREADS)-1:0]       tid_from_l2,
    output logic [31:0]                          PC_L2_i,
    output logic [127:0]                         l2_cache_block_rsp,
    output logic                                 busy
);

    import fgmt::*;

    localparam int    TID_W      = $clog2(NUM_THREADS);
    localparam word_t ALIGN_MASK = ~(32'(LINE_BYTES) - 32'd1);

    arb_state_e                   state_r;
    arb_state_e                   state_s;
    logic [TID_W-1:0]             rr_ptr_r;
    logic [NUM_THREADS-1:0]       spec_done_r;
    logic [NUM_THREADS-1:0][31:0] spec_last_r;
    logic [NUM_THREADS-1:0]       spec_elig_s;

    logic             ref_found_s;
    logic             br_found_s;
    logic             spec_found_s;
    logic [TID_W-1:0] ref_idx_s;
    logic [TID_W-1:0] br_idx_s;
    logic [TID_W-1:0] spec_idx_s;

    logic             any_s;
    logic             grant_s;
    req_class_e       sel_cls_s;
    logic [TID_W-1:0] sel_idx_s;
    word_t            sel_addr_s;

    // A held sequential prefetch is suppressed once its current line has already been fetched.
    always_comb begin
        spec_elig_s = {NUM_THREADS{1'b0}};
        for (int t = 0; t < NUM_THREADS; t++) begin
            spec_elig_s[t] = req_spec[t] &&
                !(spec_done_r[t] && (spec_last_r[t] == (spec_addr[t] & ALIGN_MASK)));
        end
    end

    rr_picker #(.N(NUM_THREADS), .W(TID_W)) u_pick_refill (
        .req   (req_refill),
        .ptr   (rr_ptr_r),
        .found (ref_found_s),
        .idx   (ref_idx_s)
    );

    rr_picker #(.N(NUM_THREADS), .W(TID_W)) u_pick_branch (
        .req   (br_req),
        .ptr   (rr_ptr_r),
        .found (br_found_s),
        .idx   (br_idx_s)
    );

    rr_picker #(.N(NUM_THREADS), .W(TID_W)) u_pick_spec (
        .req   (spec_elig_s),
        .ptr   (rr_ptr_r),
        .found (spec_found_s),
        .idx   (spec_idx_s)
    );

    // Class priority: demand refill beats branch prefetch beats sequential prefetch.
    always_comb begin
        any_s      = 1'b0;
        sel_cls_s  = CLS_REFILL;
        sel_idx_s  = {TID_W{1'b0}};
        sel_addr_s = 32'h0000_0000;
        if (ref_found_s) begin
            any_s      = 1'b1;
            sel_cls_s  = CLS_REFILL;
            sel_idx_s  = ref_idx_s;
            sel_addr_s = refill_addr[ref_idx_s] & ALIGN_MASK;
        end else if (br_found_s) begin
            any_s      = 1'b1;
            sel_cls_s  = CLS_BRANCH;
            sel_idx_s  = br_idx_s;
            sel_addr_s = br_addr[br_idx_s] & ALIGN_MASK;
        end else if (spec_found_s) begin
            any_s      = 1'b1;
            sel_cls_s  = CLS_SPEC;
            sel_idx_s  = spec_idx_s;
            sel_addr_s = spec_addr[spec_idx_s] & ALIGN_MASK;
        end else begin
            any_s      = 1'b0;
        end
    end

    // Next-state logic; arbitration only happens in IDLE.
    always_comb begin
        state_s = state_r;
        grant_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    state_s = ISSUE;
                    grant_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (l2_req_ready) begin
                    state_s = WAIT;
                end else begin
                    state_s = ISSUE;
                end
            end
            WAIT: begin
                if (l2_rsp_valid) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request/response datapath, round-robin pointer and prefetch dedup history.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_r           <= {TID_W{1'b0}};
            spec_done_r        <= {NUM_THREADS{1'b0}};
            spec_last_r        <= '0;
            l2_req_valid       <= 1'b0;
            l2_req_addr        <= 32'h0000_0000;
            l2_req_tid         <= {TID_W{1'b0}};
            rsp_valid          <= 1'b0;
            tid_from_l2        <= {TID_W{1'b0}};
            PC_L2_i            <= 32'h0000_0000;
            l2_cache_block_rsp <= 128'h0;
            busy               <= 1'b0;
        end else begin
            busy <= (state_s != IDLE);
            if (grant_s) begin
                l2_req_valid <= 1'b1;
                l2_req_addr  <= sel_addr_s;
                l2_req_tid   <= sel_idx_s;
                rr_ptr_r     <= sel_idx_s + TID_W'(1);
                if (sel_cls_s == CLS_SPEC) begin
                    spec_last_r[sel_idx_s] <= sel_addr_s;
                    spec_done_r[sel_idx_s] <= 1'b1;
                end
            end else if ((state_r == ISSUE) && l2_req_ready) begin
                l2_req_valid <= 1'b0;
            end
            if ((state_r == WAIT) && l2_rsp_valid) begin
                l2_cache_block_rsp <= l2_rsp_line;
                tid_from_l2        <= l2_req_tid;
                PC_L2_i            <= l2_req_addr;
                rsp_valid          <= 1'b1;
            end else begin
                rsp_valid          <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_l1_refill_arbiter.sv
// Scoreboard bench for l1_refill_arbiter: directed stimulus pushes expected L2
// requests and broadcasts; a negedge monitor pops and compares them.
module tb_l1_refill_arbiter;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        req_refill, br_req, req_spec;
    logic [3:0][31:0]  refill_addr, br_addr, spec_addr;
    logic              l2_req_valid, l2_req_ready;
    logic [31:0]       l2_req_addr;
    logic [1:0]        l2_req_tid;
    logic              l2_rsp_valid;
    logic [127:0]      l2_rsp_line;
    logic              rsp_valid;
    logic [1:0]        tid_from_l2;
    logic [31:0]       PC_L2_i;
    logic [127:0]      l2_cache_block_rsp;
    logic              busy;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  tid;
    } req_t;

    typedef struct {
        logic [31:0]  addr;
        logic [1:0]   tid;
        logic [127:0] line;
    } rsp_t;

    req_t exp_req[$];
    rsp_t exp_rsp[$];
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   hs_count = 0;
    int   hs0;

    always #5 clk = ~clk;

    l1_refill_arbiter #(.NUM_THREADS(4), .LINE_BYTES(16)) dut (
        .clk                (clk),
        .reset              (reset),
        .req_refill         (req_refill),
        .br_req             (br_req),
        .req_spec           (req_spec),
        .refill_addr        (refill_addr),
        .br_addr            (br_addr),
        .spec_addr          (spec_addr),
        .l2_req_valid       (l2_req_valid),
        .l2_req_ready       (l2_req_ready),
        .l2_req_addr        (l2_req_addr),
        .l2_req_tid         (l2_req_tid),
        .l2_rsp_valid       (l2_rsp_valid),
        .l2_rsp_line        (l2_rsp_line),
        .rsp_valid          (rsp_valid),
        .tid_from_l2        (tid_from_l2),
        .PC_L2_i            (PC_L2_i),
        .l2_cache_block_rsp (l2_cache_block_rsp),
        .busy               (busy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_line(input logic [31:0] a);
        return {a, ~a, a ^ 32'hA5A5_A5A5, 32'h1234_5678};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [1:0] t);
        req_t r;
        rsp_t s;
        r.addr = a; r.tid = t;
        s.addr = a; s.tid = t; s.line = mk_line(a);
        exp_req.push_back(r);
        exp_rsp.push_back(s);
    endtask

    // Plays L2: waits for the handshake, answers after dly cycles, walks through RESP.
    task automatic serve(input int dly);
        int n = 0;
        logic [31:0] a;
        while (!(l2_req_valid && l2_req_ready) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            chk("serve_timeout", 128'(l2_req_valid), 128'd1);
            return;
        end
        a = l2_req_addr;
        tick();
        repeat (dly) tick();
        l2_rsp_valid = 1'b1;
        l2_rsp_line  = mk_line(a);
        tick();
        l2_rsp_valid = 1'b0;
        chk("rsp_latency", 128'(rsp_valid), 128'd1);
        tick();
        chk("rsp_one_cycle", 128'(rsp_valid), 128'd0);
        chk("idle_after_resp", 128'(busy), 128'd0);
    endtask

    // Scoreboard monitor: every handshake and every broadcast must match the next expectation.
    always @(negedge clk) begin
        req_t r;
        rsp_t s;
        if (reset && l2_req_valid && l2_req_ready) begin
            hs_count++;
            if (exp_req.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_req: got addr %h tid %0d, required no request", l2_req_addr, l2_req_tid);
            end else begin
                r = exp_req.pop_front();
                chk("req_addr", 128'(l2_req_addr), 128'(r.addr));
                chk("req_tid", 128'(l2_req_tid), 128'(r.tid));
            end
        end
        if (rsp_valid) begin
            if (exp_rsp.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_rsp: got tid %0d pc %h, required no broadcast", tid_from_l2, PC_L2_i);
            end else begin
                s = exp_rsp.pop_front();
                chk("rsp_tid", 128'(tid_from_l2), 128'(s.tid));
                chk("rsp_pc", 128'(PC_L2_i), 128'(s.addr));
                chk("rsp_line", l2_cache_block_rsp, s.line);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        req_refill = 4'b0; br_req = 4'b0; req_spec = 4'b0;
        refill_addr = '0; br_addr = '0; spec_addr = '0;
        l2_req_ready = 1'b1; l2_rsp_valid = 1'b0; l2_rsp_line = 128'h0;
        tick(); tick();
        chk("rst_req_valid", 128'(l2_req_valid), 128'd0);
        chk("rst_req_addr", 128'(l2_req_addr), 128'd0);
        chk("rst_req_tid", 128'(l2_req_tid), 128'd0);
        chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("rst_tid_from_l2", 128'(tid_from_l2), 128'd0);
        chk("rst_pc", 128'(PC_L2_i), 128'd0);
        chk("rst_line", l2_cache_block_rsp, 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        reset = 1'b1;
        tick();

        // Single refill from T2.
        hs0 = hs_count;
        refill_addr[2] = 32'h0000_1234;
        req_refill[2]  = 1'b1;
        push(32'h0000_1230, 2'd2);
        tick();
        chk("req_latency", 128'(l2_req_valid), 128'd1);
        serve(2);
        req_refill[2] = 1'b0;
        repeat (4) tick();
        chk("single_one_req", 128'(hs_count - hs0), 128'd1);

        // Class priority: refill T3, then branch T1, then spec T0.
        refill_addr[3] = 32'h4444_4447; req_refill[3] = 1'b1;
        br_addr[1]     = 32'h5000_001F; br_req[1]     = 1'b1;
        spec_addr[0]   = 32'h6000_0020; req_spec[0]   = 1'b1;
        push(32'h4444_4440, 2'd3);
        push(32'h5000_0010, 2'd1);
        push(32'h6000_0020, 2'd0);
        serve(1); req_refill[3] = 1'b0;
        serve(0); br_req[1]     = 1'b0;
        serve(1); req_spec[0]   = 1'b0;
        repeat (3) tick();

        // Round-robin across four held refills, starting from rr_ptr=0.
        reset = 1'b0; tick(); reset = 1'b1;
        for (int t = 0; t < 4; t++) refill_addr[t] = 32'h0000_2005 + 32'(t) * 32'h100;
        req_refill = 4'b1111;
        push(32'h0000_2000, 2'd0);
        push(32'h0000_2100, 2'd1);
        push(32'h0000_2200, 2'd2);
        push(32'h0000_2300, 2'd3);
        push(32'h0000_2000, 2'd0);
        for (int i = 0; i < 5; i++) serve(0);
        req_refill = 4'b0000;
        repeat (3) tick();

        // Sequential prefetch dedup on T1.
        reset = 1'b0; tick(); reset = 1'b1;
        hs0 = hs_count;
        spec_addr[1] = 32'h0000_0100; req_spec[1] = 1'b1;
        push(32'h0000_0100, 2'd1);
        serve(1);
        repeat (10) tick();
        chk("dedup_no_reissue", 128'(hs_count - hs0), 128'd1);
        chk("dedup_idle", 128'(busy), 128'd0);
        spec_addr[1] = 32'h0000_0110;
        push(32'h0000_0110, 2'd1);
        serve(1);
        req_spec[1] = 1'b0;
        repeat (2) tick();

        // Back-pressure with a spurious response during ISSUE; also checks the top-of-space alignment.
        l2_req_ready = 1'b0;
        refill_addr[2] = 32'hFFFF_FFFC; req_refill[2] = 1'b1;
        begin
            req_t r;
            r.addr = 32'hFFFF_FFF0; r.tid = 2'd2;
            exp_req.push_back(r);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 128'(l2_req_valid), 128'd1);
            chk("bp_addr", 128'(l2_req_addr), 128'hFFFF_FFF0);
            chk("bp_tid", 128'(l2_req_tid), 128'd2);
            l2_rsp_valid = (i == 2);
            l2_rsp_line  = 128'hDEAD;
            tick();
            chk("bp_no_rsp", 128'(rsp_valid), 128'd0);
        end
        l2_rsp_valid = 1'b0;
        begin
            rsp_t s;
            s.addr = 32'hFFFF_FFF0; s.tid = 2'd2; s.line = mk_line(32'hFFFF_FFF0);
            exp_rsp.push_back(s);
        end
        l2_req_ready = 1'b1;
        serve(1);
        req_refill[2] = 1'b0;
        repeat (2) tick();

        // Reset while waiting on L2; the late response must be ignored and rr_ptr restarts at 0.
        refill_addr[2] = 32'h0000_3008; req_refill[2] = 1'b1;
        begin
            req_t r;
            r.addr = 32'h0000_3000; r.tid = 2'd2;
            exp_req.push_back(r);
        end
        tick();
        tick();
        chk("wait_busy", 128'(busy), 128'd1);
        reset = 1'b0; req_refill[2] = 1'b0;
        tick();
        reset = 1'b1;
        l2_rsp_valid = 1'b1; l2_rsp_line = 128'hBAD;
        tick();
        l2_rsp_valid = 1'b0;
        chk("late_rsp_ignored", 128'(rsp_valid), 128'd0);
        chk("late_busy", 128'(busy), 128'd0);
        chk("late_req_valid", 128'(l2_req_valid), 128'd0);
        tick();
        chk("late_rsp_ignored2", 128'(rsp_valid), 128'd0);
        refill_addr[1] = 32'h0000_7011; refill_addr[3] = 32'h0000_8033;
        req_refill[1] = 1'b1; req_refill[3] = 1'b1;
        push(32'h0000_7010, 2'd1);
        push(32'h0000_8030, 2'd3);
        serve(0);
        serve(0);
        req_refill = 4'b0000;
        repeat (4) tick();

        chk("req_queue_drained", 128'(exp_req.size()), 128'd0);
        chk("rsp_queue_drained", 128'(exp_rsp.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
